// File: rtl/alu_add_sequencer.sv
// alu_add_sequencer: multi-cycle add/subtract controller around a single
// 64-bit carry-lookahead adder. 128-bit ops chain two adder passes. The block
// owns the architectural flags register {SF,CF,OF,PF,ZF}.
//
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high. The request side is ready only in IDLE. The response side holds
// rsp_valid and its payload stable until it is accepted.

// 64-bit carry-lookahead adder: 4-bit lookahead groups with a group carry chain.
module alu_add_cla64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        c_i,
    output logic [63:0] sum_o,
    output logic        cout_o,
    output logic        ovf_o
);
    logic [63:0] g;
    logic [63:0] p;
    logic [15:0] gg;
    logic [15:0] pg;
    logic [64:0] c;

    // Generate/propagate, group lookahead terms and carries, then sum bits.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = '0;
        pg = '0;
        c  = '0;
        c[0] = c_i;
        for (int k = 0; k < 16; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = gg[k] | (pg[k] & c[4*k]);
        end
        sum_o  = p ^ c[63:0];
        cout_o = c[64];
        ovf_o  = c[64] ^ c[63];
    end
endmodule

module alu_add_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_sum,
    output logic [4:0]   rsp_flags,
    output logic         rsp_err,
    output logic [4:0]   flags_q,
    input  logic         flags_we,
    input  logic [4:0]   flags_wdata,
    output logic [1:0]   dbg_state_o
);
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_ADC    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_SBB    = 3'b011;
    localparam logic [2:0] OP_CMP    = 3'b100;
    localparam logic [2:0] OP_ADD128 = 3'b101;
    localparam logic [2:0] OP_SUB128 = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC_LO = 2'd1,
        S_EXEC_HI = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [127:0] a_q, a_d;
    logic [127:0] b_q, b_d;
    logic         carry_q, carry_d;
    logic [63:0]  sum_lo_q, sum_lo_d;
    logic [127:0] rsp_sum_q, rsp_sum_d;
    logic [4:0]   rsp_flags_q, rsp_flags_d;
    logic         rsp_err_q, rsp_err_d;
    logic [4:0]   flags_d;

    logic         is_sub;
    logic         is_128;
    logic [63:0]  add_a;
    logic [63:0]  add_b_raw;
    logic [63:0]  add_b;
    logic         add_cin;
    logic [63:0]  add_sum;
    logic         add_cout;
    logic         add_ovf;
    logic [127:0] res_full;
    logic [4:0]   calc_flags;

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_sum     = rsp_sum_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state_o = state_q;

    // Adder operand/carry-in selection for the current pass, plus final-pass flags.
    always_comb begin
        is_sub    = (op_q == OP_SUB) || (op_q == OP_SBB) ||
                    (op_q == OP_CMP) || (op_q == OP_SUB128);
        is_128    = (op_q == OP_ADD128) || (op_q == OP_SUB128);
        add_a     = (state_q == S_EXEC_HI) ? a_q[127:64] : a_q[63:0];
        add_b_raw = (state_q == S_EXEC_HI) ? b_q[127:64] : b_q[63:0];
        add_b     = is_sub ? ~add_b_raw : add_b_raw;
        add_cin   = 1'b0;
        if (state_q == S_EXEC_HI) begin
            add_cin = carry_q;
        end else begin
            case (op_q)
                OP_ADC:                   add_cin = flags_q[3];
                OP_SBB:                   add_cin = ~flags_q[3];
                OP_SUB, OP_CMP, OP_SUB128: add_cin = 1'b1;
                default:                  add_cin = 1'b0;
            endcase
        end
        // The low half is already registered when the high pass runs.
        res_full   = is_128 ? {add_sum, sum_lo_q} : {64'd0, add_sum};
        calc_flags = {add_sum[63],
                      is_sub ? ~add_cout : add_cout,
                      add_ovf,
                      ^res_full,
                      (res_full == 128'd0)};
    end

    alu_add_cla64 u_cla (
        .a_i    (add_a),
        .b_i    (add_b),
        .c_i    (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_lo_d    = sum_lo_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        flags_d     = flags_q;
        case (state_q)
            S_IDLE: begin
                if (flags_we) begin
                    flags_d = flags_wdata;
                end
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (req_op == OP_RSVD) begin
                        state_d     = S_RESP;
                        rsp_sum_d   = 128'd0;
                        rsp_flags_d = flags_we ? flags_wdata : flags_q;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = S_EXEC_LO;
                    end
                end
            end
            S_EXEC_LO: begin
                sum_lo_d = add_sum;
                carry_d  = add_cout;
                if (is_128) begin
                    state_d = S_EXEC_HI;
                end else begin
                    state_d     = S_RESP;
                    rsp_sum_d   = (op_q == OP_CMP) ? 128'd0 : {64'd0, add_sum};
                    rsp_flags_d = calc_flags;
                    rsp_err_d   = 1'b0;
                    flags_d     = calc_flags;
                end
            end
            S_EXEC_HI: begin
                state_d     = S_RESP;
                rsp_sum_d   = {add_sum, sum_lo_q};
                rsp_flags_d = calc_flags;
                rsp_err_d   = 1'b0;
                flags_d     = calc_flags;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            a_q         <= 128'd0;
            b_q         <= 128'd0;
            carry_q     <= 1'b0;
            sum_lo_q    <= 64'd0;
            rsp_sum_q   <= 128'd0;
            rsp_flags_q <= 5'd0;
            rsp_err_q   <= 1'b0;
            flags_q     <= 5'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_lo_q    <= sum_lo_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            flags_q     <= flags_d;
        end
    end
endmodule

// File: tb/tb_alu_add_sequencer.sv
// Bench for alu_add_sequencer: randomized and directed requests, a reference
// model using exact wide arithmetic, and a scoreboard popped by a monitor.
module tb_alu_add_sequencer;
    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_sum;
    logic [4:0]   rsp_flags;
    logic         rsp_err;
    logic [4:0]   flags_q;
    logic         flags_we;
    logic [4:0]   flags_wdata;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    logic hold_low = 1'b0;
    logic seen_valid = 1'b0;
    logic [4:0] model_flags = 5'd0;

    logic [127:0] exp_sum_q[$];
    logic [4:0]   exp_flags_q[$];
    logic [0:0]   exp_err_q[$];
    logic [4:0]   exp_fq_q[$];
    int           exp_acc_q[$];
    int           exp_lat_q[$];

    alu_add_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_sum     (rsp_sum),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err),
        .flags_q     (flags_q),
        .flags_we    (flags_we),
        .flags_wdata (flags_wdata),
        .dbg_state_o (dbg_state)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: exact wide arithmetic; borrow = negative difference,
    // overflow = exact signed result not representable in the result width.
    function automatic void model(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b,
                                  input logic [4:0] fl, output logic [127:0] sum, output logic [4:0] fo);
        logic [129:0] ua, ub, sa, sb, u, s, cin;
        logic [127:0] res;
        logic cf, of, sf, w128, sub;
        cin  = {129'd0, fl[3]};
        w128 = (op == 3'd5) || (op == 3'd6);
        sub  = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd6);
        if (w128) begin
            ua = {2'b00, a};
            ub = {2'b00, b};
            sa = {{2{a[127]}}, a};
            sb = {{2{b[127]}}, b};
        end else begin
            ua = {66'd0, a[63:0]};
            ub = {66'd0, b[63:0]};
            sa = {{66{a[63]}}, a[63:0]};
            sb = {{66{b[63]}}, b[63:0]};
        end
        case (op)
            3'd0, 3'd5: begin u = ua + ub;       s = sa + sb;       end
            3'd1:       begin u = ua + ub + cin; s = sa + sb + cin; end
            3'd3:       begin u = ua - ub - cin; s = sa - sb - cin; end
            default:    begin u = ua - ub;       s = sa - sb;       end
        endcase
        if (sub) cf = u[129];
        else     cf = w128 ? u[128] : u[64];
        res = w128 ? u[127:0] : {64'd0, u[63:0]};
        of  = w128 ? (s != {{2{s[127]}}, s[127:0]}) : (s != {{66{s[63]}}, s[63:0]});
        sf  = w128 ? res[127] : res[63];
        fo  = {sf, cf, of, ^res, (res == 128'd0)};
        sum = (op == 3'd4) ? 128'd0 : res;
    endfunction

    // driver: present a request, wait (bounded) for acceptance, push expectations
    task automatic send(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b,
                        input logic we, input logic [4:0] wd);
        logic [127:0] es;
        logic [4:0]   ef;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        flags_we = we; flags_wdata = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
            req_valid = 1'b0; flags_we = 1'b0;
            return;
        end
        if (we) model_flags = wd;
        if (op == 3'd7) begin
            exp_sum_q.push_back(128'd0);
            exp_flags_q.push_back(model_flags);
            exp_err_q.push_back(1'b1);
            exp_lat_q.push_back(1);
        end else begin
            model(op, a, b, model_flags, es, ef);
            model_flags = ef;
            exp_sum_q.push_back(es);
            exp_flags_q.push_back(ef);
            exp_err_q.push_back(1'b0);
            exp_lat_q.push_back((op == 3'd5 || op == 3'd6) ? 3 : 2);
        end
        exp_fq_q.push_back(model_flags);
        exp_acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flags_we  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_sum_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_sum_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_sum_q.size());
            exp_sum_q.delete(); exp_flags_q.delete(); exp_err_q.delete();
            exp_fq_q.delete(); exp_acc_q.delete(); exp_lat_q.delete();
        end
        @(negedge clk);
    endtask

    // monitor: drive rsp_ready, check latency on first valid, pop on handshake
    always @(negedge clk) begin
        rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (rst_n) begin
            if (rsp_valid && !seen_valid) begin
                seen_valid = 1'b1;
                if (exp_lat_q.size() != 0)
                    check("latency", 128'(cyc - exp_acc_q[0]), 128'(exp_lat_q[0]));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_sum_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got sum %h expected no response", rsp_sum);
                end else begin
                    check("rsp_sum", rsp_sum, exp_sum_q.pop_front());
                    check("rsp_flags", 128'(rsp_flags), 128'(exp_flags_q.pop_front()));
                    check("rsp_err", 128'(rsp_err), 128'(exp_err_q.pop_front()));
                    check("flags_q_at_rsp", 128'(flags_q), 128'(exp_fq_q.pop_front()));
                    void'(exp_acc_q.pop_front());
                    void'(exp_lat_q.pop_front());
                end
                seen_valid = 1'b0;
                pops++;
            end
        end
    end

    function automatic logic [127:0] rand_opnd();
        logic [127:0] v;
        case ($urandom_range(0, 4))
            0:       v = '1;
            1:       v = '0;
            2:       v = 128'($urandom_range(0, 15));
            3:       v = {64'($urandom_range(0, 3)), 1'b1, 63'd0};
            default: v = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        int n;
        int p0;
        logic [2:0] op;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0;
        flags_we = 1'b0; flags_wdata = 5'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 128'(req_ready), 128'd1);
        check("reset_rsp_valid", 128'(rsp_valid), 128'd0);
        check("reset_rsp_sum", rsp_sum, 128'd0);
        check("reset_rsp_flags", 128'(rsp_flags), 128'd0);
        check("reset_rsp_err", 128'(rsp_err), 128'd0);
        check("reset_flags_q", 128'(flags_q), 128'd0);

        // ADD all-ones + 1 -> zero with carry
        send(3'd0, 128'hFFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 5'd0);
        drain();
        check("add_wrap_flags_q", 128'(flags_q), 128'(5'b01001));

        // SUB 5-7 then CMP signed-overflow case
        send(3'd2, 128'd5, 128'd7, 1'b0, 5'd0);
        drain();
        check("sub_flags_q", 128'(flags_q), 128'(5'b11010));
        send(3'd4, 128'h8000_0000_0000_0000, 128'd1, 1'b0, 5'd0);
        drain();
        check("cmp_flags_q", 128'(flags_q), 128'(5'b00110));

        // flags write with CF=1 in the ADC accept cycle
        send(3'd1, 128'd1, 128'd1, 1'b1, 5'b01000);
        drain();
        check("adc_flags_q", 128'(flags_q), 128'(5'b00000));

        // flags write during EXEC_LO must be ignored
        send(3'd0, 128'd1, 128'd1, 1'b0, 5'd0);
        flags_we = 1'b1; flags_wdata = 5'h1F;
        @(posedge clk);
        #1;
        flags_we = 1'b0;
        drain();
        check("we_in_exec_ignored", 128'(flags_q), 128'(5'b00010));

        // 128-bit ops
        send(3'd5, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 5'd0);
        drain();
        check("add128_flags_q", 128'(flags_q), 128'(5'b00010));
        send(3'd6, 128'd0, 128'd1, 1'b0, 5'd0);
        drain();
        check("sub128_flags_q", 128'(flags_q), 128'(5'b11000));

        // backpressure: response held stable for 5 cycles
        hold_low = 1'b1;
        send(3'd2, 128'd5, 128'd7, 1'b0, 5'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", 128'(rsp_valid), 128'd1);
            check("stall_rsp_sum", rsp_sum, 128'hFFFF_FFFF_FFFF_FFFE);
            check("stall_rsp_flags", 128'(rsp_flags), 128'(5'b11010));
            check("stall_req_ready", 128'(req_ready), 128'd0);
            @(negedge clk);
        end
        p0 = pops;
        hold_low = 1'b0;
        n = 0;
        while (pops == p0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("ready_after_hs", 128'(req_ready), 128'd1);

        // reserved op: err, flags_q unchanged
        send(3'd7, 128'd9, 128'd9, 1'b0, 5'd0);
        drain();
        check("rsvd_flags_q", 128'(flags_q), 128'(5'b11010));

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            send(op, rand_opnd(), rand_opnd(),
                 (op != 3'd7) && ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
        end
        drain();

        // reset during EXEC_HI of ADD128
        send(3'd5, 128'd3, 128'd4, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 128'(rsp_valid), 128'd0);
        check("abort_flags_q", 128'(flags_q), 128'd0);
        exp_sum_q.delete(); exp_flags_q.delete(); exp_err_q.delete();
        exp_fq_q.delete(); exp_acc_q.delete(); exp_lat_q.delete();
        seen_valid = 1'b0;
        model_flags = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 128'(req_ready), 128'd1);
        send(3'd0, 128'd2, 128'd3, 1'b0, 5'd0);
        drain();
        check("post_reset_flags_q", 128'(flags_q), 128'(5'b00000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
